mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port word memory.
//   Requester 0 is instruction fetch, requester 1 is data access. At most
//   one transaction is in flight: IDLE -> ISSUE (memory strobes active,
//   extended while mem_wait is high) -> RESP (done/err pulse) -> IDLE.
//   A transaction stalled for WAIT_MAX consecutive ISSUE cycles is aborted.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   : round-robin tie-break (requester 0 wins the
//                              first tie after reset)
//                  undefined : fixed priority, requester 1 wins ties
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rN_req/addr/wdata/we/         request fields of requester N (0, 1)
//   rN_byte_en/byte_sel
//   rN_done, rN_err               one-cycle completion / abort pulses
//   rN_rdata                      read data, held until next read completion
//   mem_en/we/byte_en/byte_sel    memory strobes (active only in ISSUE)
//   mem_addr, mem_wdata           memory address (held) and write data
//   mem_rdata, mem_wait           memory read data and stall
//   busy                          high whenever a transaction is in flight
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_we,
  input  logic              r0_byte_en,
  input  logic              r0_byte_sel,
  output logic              r0_done,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_we,
  input  logic              r1_byte_en,
  input  logic              r1_byte_sel,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte_en,
  output logic              mem_byte_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wait,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  // Abort fires on the stalled cycle that brings the count to WAIT_MAX.
  localparam logic [7:0] STALL_LAST = 8'(WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [7:0]        stall_q, stall_d;
  logic              abort_q, abort_d;
  logic              win_q;
  logic              grant;
  logic              any_req;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, ben_q, bsel_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign any_req = r0_req | r1_req;

`ifdef MEM_ARB_RR_EN
  // Most recently granted requester; resets to 1 so requester 0 wins first tie.
  logic last_q;

  always_comb begin
    if (r0_req && r1_req) grant = ~last_q;
    else                  grant = r1_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           last_q <= 1'b1;
    else if (state_q == IDLE && any_req) last_q <= grant;
  end
`else
  always_comb grant = r1_req;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          stall_d = '0;
          abort_d = 1'b0;
        end
      end
      ISSUE: begin
        if (!mem_wait) begin
          state_d = RESP;
        end else begin
          stall_d = stall_q + 8'd1;
          if (stall_q == STALL_LAST) begin
            state_d = RESP;
            abort_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once on grant; read data on non-aborted reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ben_q    <= 1'b0;
      bsel_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        win_q   <= grant;
        addr_q  <= grant ? r1_addr     : r0_addr;
        wdata_q <= grant ? r1_wdata    : r0_wdata;
        we_q    <= grant ? r1_we       : r0_we;
        ben_q   <= grant ? r1_byte_en  : r0_byte_en;
        bsel_q  <= grant ? r1_byte_sel : r0_byte_sel;
      end
      if (state_q == RESP && !abort_q && !we_q) begin
        if (win_q) rdata1_q <= mem_rdata;
        else       rdata0_q <= mem_rdata;
      end
    end
  end

  // Output decode
  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_byte_en  = 1'b0;
    mem_byte_sel = 1'b0;
    mem_wdata    = '0;
    r0_done      = 1'b0;
    r1_done      = 1'b0;
    r0_err       = 1'b0;
    r1_err       = 1'b0;
    unique case (state_q)
      ISSUE: begin
        mem_en       = 1'b1;
        mem_we       = we_q;
        mem_byte_en  = ben_q;
        mem_byte_sel = bsel_q;
        mem_wdata    = wdata_q;
      end
      RESP: begin
        r0_done = ~win_q;
        r1_done = win_q;
        r0_err  = ~win_q & abort_q;
        r1_err  = win_q & abort_q;
      end
      default: ;
    endcase
  end

  assign mem_addr = addr_q;
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;
  assign busy     = (state_q != IDLE);

endmodule
